// File: rtl/mu0_datapath_p_if.sv
// ============================================================================
// mu0_datapath_p_if : control/memory-side bus of the parametrised MU0 datapath
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface mu0_datapath_p_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic [DATA_W-1:0] din;
  logic              x_sel;
  logic              y_sel;
  logic              addr_sel;
  logic              pc_en;
  logic              ir_en;
  logic              acc_en;
  logic [1:0]        m;
  logic              mul_start;

  logic [3:0]        f;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] dout;
  logic              n;
  logic              z;
  logic              c;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] acc;
  logic              busy;
  logic              done;

  modport master (
    output din, x_sel, y_sel, addr_sel, pc_en, ir_en, acc_en, m, mul_start,
    input  f, address, dout, n, z, c, pc, acc, busy, done
  );

  modport slave (
    input  din, x_sel, y_sel, addr_sel, pc_en, ir_en, acc_en, m, mul_start,
    output f, address, dout, n, z, c, pc, acc, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/mu0_datapath_p.sv
// ============================================================================
// mu0_datapath_p : parametrised MU0 datapath (Acc/PC/IR, 4-op ALU, N/Z/C) with
//                  optional iterative shift-add multiplier, built when the
//                  macro MU0_MUL_EN is defined.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mu0_datapath_p #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  wire                    clk,
  input  wire                    rst,
  mu0_datapath_p_if.slave        bus
);
  localparam int EXT_W = DATA_W - ADDR_W;

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              c_q, c_d;

  logic [DATA_W-1:0] x_val;
  logic [DATA_W-1:0] y_val;
  logic [DATA_W-1:0] alu;
  logic              alu_c;
  logic [DATA_W:0]   alu_wide;

  logic              busy;
  logic              done;
  logic              mul_go;
  logic              mul_wr;
  logic [DATA_W-1:0] mul_res;
  logic              acc_load;

  always_comb begin
    x_val = bus.x_sel ? {{EXT_W{1'b0}}, pc_q} : acc_q;
    y_val = bus.y_sel ? bus.din : {{EXT_W{1'b0}}, ir_q[ADDR_W-1:0]};
  end

  // Subtract carry is the no-borrow flag, i.e. X >= Y unsigned.
  always_comb begin
    alu_wide = '0;
    alu      = y_val;
    alu_c    = 1'b0;
    case (bus.m)
      2'b01: begin
        alu_wide = {1'b0, x_val} + {1'b0, y_val};
        alu      = alu_wide[DATA_W-1:0];
        alu_c    = alu_wide[DATA_W];
      end
      2'b10: begin
        alu_wide = {1'b0, x_val} + {{DATA_W{1'b0}}, 1'b1};
        alu      = alu_wide[DATA_W-1:0];
        alu_c    = alu_wide[DATA_W];
      end
      2'b11: begin
        alu_wide = {1'b0, x_val} - {1'b0, y_val};
        alu      = alu_wide[DATA_W-1:0];
        alu_c    = ~alu_wide[DATA_W];
      end
      default: begin
        alu      = y_val;
        alu_c    = 1'b0;
      end
    endcase
  end

  assign acc_load = bus.acc_en && !busy && !mul_go;

  always_comb begin
    acc_d = acc_q;
    pc_d  = pc_q;
    ir_d  = ir_q;
    c_d   = c_q;
    if (mul_wr) begin
      acc_d = mul_res;
    end else if (acc_load) begin
      acc_d = alu;
      if (bus.m != 2'b00) c_d = alu_c;
    end
    if (bus.pc_en && !busy) pc_d = alu[ADDR_W-1:0];
    if (bus.ir_en && !busy) ir_d = bus.din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      c_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      c_q   <= c_d;
    end
  end

`ifdef MU0_MUL_EN
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mul_state_t;

  mul_state_t        state_q, state_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] prod_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      count_q  <= count_d;
      done_q   <= done_d;
    end
  end

  // Only the low DATA_W product bits are kept, so mcand may shift out its top.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    count_d   = count_q;
    done_d    = 1'b0;
    mul_go    = 1'b0;
    mul_wr    = 1'b0;
    prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    if (state_q == S_IDLE) begin
      if (bus.mul_start) begin
        mul_go   = 1'b1;
        mcand_d  = acc_q;
        mplier_d = y_val;
        prod_d   = '0;
        count_d  = '0;
        state_d  = S_RUN;
      end
    end else begin
      prod_d   = prod_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CNT_W'(1);
      if (count_q == CNT_W'(DATA_W - 1)) begin
        mul_wr  = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = done_q;
  assign mul_res = prod_step;
`else
  logic unused_mul_start;

  assign unused_mul_start = bus.mul_start;
  assign busy             = 1'b0;
  assign done             = 1'b0;
  assign mul_go           = 1'b0;
  assign mul_wr           = 1'b0;
  assign mul_res          = '0;
`endif

  if (DATA_W > ADDR_W + 4) begin : g_ir_mid
    logic unused_ir_mid;
    assign unused_ir_mid = ^ir_q[DATA_W-5:ADDR_W];
  end

  assign bus.f       = ir_q[DATA_W-1 -: 4];
  assign bus.address = bus.addr_sel ? ir_q[ADDR_W-1:0] : pc_q;
  assign bus.dout    = x_val;
  assign bus.n       = acc_q[DATA_W-1];
  assign bus.z       = (acc_q == '0);
  assign bus.c       = c_q;
  assign bus.pc      = pc_q;
  assign bus.acc     = acc_q;
  assign bus.busy    = busy;
  assign bus.done    = done;

endmodule

`default_nettype wire

// File: tb/tb_mu0_datapath_p.sv
// ============================================================================
// tb_mu0_datapath_p : directed self-checking bench for mu0_datapath_p
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mu0_datapath_p;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  mu0_datapath_p_if #(.DATA_W(16), .ADDR_W(12)) bus ();

  mu0_datapath_p #(.DATA_W(16), .ADDR_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] din;
    logic        x_sel;
    logic        y_sel;
    logic        addr_sel;
    logic        pc_en;
    logic        ir_en;
    logic        acc_en;
    logic [1:0]  m;
    logic [15:0] acc;
    logic [11:0] pc;
    logic        c;
    logic [11:0] addr;
    logic [3:0]  f;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pc_en     = 1'b0;
    bus.ir_en     = 1'b0;
    bus.acc_en    = 1'b0;
    bus.mul_start = 1'b0;
    bus.x_sel     = 1'b0;
    bus.addr_sel  = 1'b0;
  endtask

  task automatic load_acc(input logic [15:0] v);
    bus.din    = v;
    bus.y_sel  = 1'b1;
    bus.x_sel  = 1'b0;
    bus.m      = 2'b00;
    bus.acc_en = 1'b1;
    tick();
    bus.acc_en = 1'b0;
  endtask

`ifdef MU0_MUL_EN
  // Starts a multiply Acc x b with a competing Acc_En, optionally pokes the
  // enables mid-run, and returns in the Done cycle.
  task automatic mul_and_check(input logic [15:0] b, input logic [15:0] start,
                               input logic [15:0] exp, input logic exp_c,
                               input bit poke);
    int cnt;
    bus.din       = b;
    bus.y_sel     = 1'b1;
    bus.m         = 2'b00;
    bus.acc_en    = 1'b1;
    bus.mul_start = 1'b1;
    tick();
    bus.acc_en    = 1'b0;
    bus.mul_start = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      cnt++;
      if (cnt == 1 || cnt == 9) chk("mul_acc_hold", bus.acc, start);
      if (poke && cnt == 8) begin
        bus.acc_en    = 1'b1;
        bus.mul_start = 1'b1;
        bus.din       = 16'hFFFF;
      end else begin
        bus.acc_en    = 1'b0;
        bus.mul_start = 1'b0;
      end
      tick();
    end
    bus.acc_en    = 1'b0;
    bus.mul_start = 1'b0;
    chk("mul_busy_cycles", cnt, 16);
    chk("mul_done_high", bus.done, 1'b1);
    chk("mul_result", bus.acc, exp);
    chk("mul_c_kept", bus.c, exp_c);
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    bus.din = '0;
    bus.y_sel = 1'b0;
    bus.m = 2'b00;
    idle_inputs();

    //            din      x  y  a  pe ie ae m      acc      pc      c  addr    f     dout
    vecs[0]  = '{16'hFFFF, 0, 1, 0, 0, 0, 1, 2'b00, 16'hFFFF, 12'h000, 0, 12'h000, 4'h0, 16'hFFFF};
    vecs[1]  = '{16'h0001, 0, 1, 0, 0, 0, 1, 2'b01, 16'h0000, 12'h000, 1, 12'h000, 4'h0, 16'h0000};
    vecs[2]  = '{16'h0003, 0, 1, 0, 0, 0, 1, 2'b00, 16'h0003, 12'h000, 1, 12'h000, 4'h0, 16'h0003};
    vecs[3]  = '{16'h0005, 0, 1, 0, 0, 0, 1, 2'b11, 16'hFFFE, 12'h000, 0, 12'h000, 4'h0, 16'hFFFE};
    vecs[4]  = '{16'h0002, 0, 1, 0, 0, 0, 1, 2'b11, 16'hFFFC, 12'h000, 1, 12'h000, 4'h0, 16'hFFFC};
    vecs[5]  = '{16'h5FFF, 0, 1, 1, 0, 1, 0, 2'b00, 16'hFFFC, 12'h000, 1, 12'hFFF, 4'h5, 16'hFFFC};
    vecs[6]  = '{16'h1234, 1, 0, 0, 1, 0, 0, 2'b01, 16'hFFFC, 12'hFFF, 1, 12'hFFF, 4'h5, 16'h0FFF};
    vecs[7]  = '{16'h1234, 1, 0, 0, 1, 0, 0, 2'b10, 16'hFFFC, 12'h000, 1, 12'h000, 4'h5, 16'h0000};
    vecs[8]  = '{16'h1234, 1, 0, 0, 0, 0, 1, 2'b01, 16'h0FFF, 12'h000, 0, 12'h000, 4'h5, 16'h0000};
    vecs[9]  = '{16'h1234, 0, 0, 0, 0, 0, 1, 2'b10, 16'h1000, 12'h000, 0, 12'h000, 4'h5, 16'h1000};
    vecs[10] = '{16'h1000, 0, 1, 0, 0, 0, 1, 2'b11, 16'h0000, 12'h000, 1, 12'h000, 4'h5, 16'h0000};
    vecs[11] = '{16'h1234, 0, 1, 0, 0, 0, 0, 2'b01, 16'h0000, 12'h000, 1, 12'h000, 4'h5, 16'h0000};

    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_acc", bus.acc, 16'h0000);
    chk("rst_pc", bus.pc, 12'h000);
    chk("rst_f", bus.f, 4'h0);
    chk("rst_c", bus.c, 1'b0);
    chk("rst_z", bus.z, 1'b1);
    chk("rst_n", bus.n, 1'b0);
    chk("rst_addr", bus.address, 12'h000);
    chk("rst_dout", bus.dout, 16'h0000);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);

    for (int i = 0; i < 12; i++) begin
      bus.din      = vecs[i].din;
      bus.x_sel    = vecs[i].x_sel;
      bus.y_sel    = vecs[i].y_sel;
      bus.addr_sel = vecs[i].addr_sel;
      bus.pc_en    = vecs[i].pc_en;
      bus.ir_en    = vecs[i].ir_en;
      bus.acc_en   = vecs[i].acc_en;
      bus.m        = vecs[i].m;
      tick();
      chk($sformatf("v%0d_acc", i), bus.acc, vecs[i].acc);
      chk($sformatf("v%0d_pc", i), bus.pc, vecs[i].pc);
      chk($sformatf("v%0d_c", i), bus.c, vecs[i].c);
      chk($sformatf("v%0d_n", i), bus.n, vecs[i].acc[15]);
      chk($sformatf("v%0d_z", i), bus.z, (vecs[i].acc == 16'h0000));
      chk($sformatf("v%0d_addr", i), bus.address, vecs[i].addr);
      chk($sformatf("v%0d_f", i), bus.f, vecs[i].f);
      chk($sformatf("v%0d_dout", i), bus.dout, vecs[i].dout);
    end
    idle_inputs();

    // Build up non-zero state, then reset asynchronously mid-cycle.
    bus.x_sel = 1'b1;
    bus.m     = 2'b10;
    bus.pc_en = 1'b1;
    tick();
    bus.pc_en = 1'b0;
    chk("pc_inc", bus.pc, 12'h001);
    load_acc(16'h8001);
    chk("pre_rst_n", bus.n, 1'b1);
    idle_inputs();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_acc", bus.acc, 16'h0000);
    chk("arst_pc", bus.pc, 12'h000);
    chk("arst_f", bus.f, 4'h0);
    chk("arst_c", bus.c, 1'b0);
    chk("arst_z", bus.z, 1'b1);
    chk("arst_busy", bus.busy, 1'b0);
    tick();
    rst = 1'b0;

`ifdef MU0_MUL_EN
    load_acc(16'h000A);
    bus.din    = 16'h0003;
    bus.m      = 2'b11;
    bus.acc_en = 1'b1;
    tick();
    bus.acc_en = 1'b0;
    chk("pre_mul_acc", bus.acc, 16'h0007);
    chk("pre_mul_c", bus.c, 1'b1);
    mul_and_check(16'h0006, 16'h0007, 16'h002A, 1'b1, 1'b1);
    mul_and_check(16'h0002, 16'h002A, 16'h0054, 1'b1, 1'b0);
    tick();
    chk("done_width", bus.done, 1'b0);
    load_acc(16'h0100);
    mul_and_check(16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0);
    chk("mul_z", bus.z, 1'b1);
    tick();

    begin
      bit seen_done;
      load_acc(16'h0007);
      bus.din       = 16'h0005;
      bus.mul_start = 1'b1;
      tick();
      bus.mul_start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("abort_busy_pre", bus.busy, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_acc", bus.acc, 16'h0000);
      tick();
      rst = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (bus.done || bus.busy) seen_done = 1'b1;
      end
      chk("abort_no_done", seen_done, 1'b0);
    end
    load_acc(16'h0003);
    mul_and_check(16'h0003, 16'h0003, 16'h0009, 1'b0, 1'b0);
    tick();
`else
    bus.din       = 16'h0042;
    bus.y_sel     = 1'b1;
    bus.m         = 2'b00;
    bus.acc_en    = 1'b1;
    bus.mul_start = 1'b1;
    tick();
    bus.acc_en    = 1'b0;
    chk("nomul_acc_load", bus.acc, 16'h0042);
    chk("nomul_busy", bus.busy, 1'b0);
    tick();
    chk("nomul_busy2", bus.busy, 1'b0);
    chk("nomul_done", bus.done, 1'b0);
    bus.mul_start = 1'b0;
    bus.x_sel     = 1'b1;
    bus.m         = 2'b10;
    bus.pc_en     = 1'b1;
    tick();
    bus.pc_en     = 1'b0;
    chk("nomul_pc_load", bus.pc, 12'h001);
    chk("nomul_acc_kept", bus.acc, 16'h0042);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
